// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared definitions for the PS/2 host-side blocks.
//   ps2TxState_t : host transmit FSM states
//   usToCycles   : microseconds -> system clock cycles (integer MHz scaling)
//   oddParity    : PS/2 parity bit for a data byte
//   FRAME_CLOCKS : device clocks per host-to-device frame
package ps2_pkg;

  localparam int unsigned FRAME_CLOCKS = 11;
  localparam logic        ODD_PARITY   = 1'b1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INHIBIT  = 3'd1,
    REQ      = 3'd2,
    DATA     = 3'd3,
    PARITY   = 3'd4,
    STOP     = 3'd5,
    ACK      = 3'd6,
    WAITIDLE = 3'd7
  } ps2TxState_t;

  // Scale by whole MHz first so the result matches the legacy integer maths.
  function automatic int unsigned usToCycles(input int unsigned clkHz,
                                             input int unsigned us);
    return (clkHz / 1000000) * us;
  endfunction

  function automatic logic oddParity(input logic [7:0] d);
    return (^d) ^ ODD_PARITY;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge -- 2-FF synchroniser for the PS/2 clock and data lines plus a
// falling-edge detector on the synchronised clock. Flops reset to the idle-high
// line level so reset never produces a spurious edge.
//   clk, rstN : system clock, async active-low reset
//   clkIn     : raw PS/2 clock line
//   dataIn    : raw PS/2 data line
//   clkSync   : synchronised clock line
//   dataSync  : synchronised data line
//   fallEdge  : one-cycle pulse on a clkSync 1->0 transition
module ps2_sync_edge (
  input  logic clk,
  input  logic rstN,
  input  logic clkIn,
  input  logic dataIn,
  output logic clkSync,
  output logic dataSync,
  output logic fallEdge
);

  logic [1:0] clkFf;
  logic [1:0] dataFf;
  logic       clkPrev;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      clkFf   <= '1;
      dataFf  <= '1;
      clkPrev <= 1'b1;
    end else begin
      clkFf   <= {clkFf[0], clkIn};
      dataFf  <= {dataFf[0], dataIn};
      clkPrev <= clkFf[1];
    end
  end

  assign clkSync  = clkFf[1];
  assign dataSync = dataFf[1];
  assign fallEdge = clkPrev & ~clkFf[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device command transmitter (open-drain lines).
// Inhibits the device clock, issues request-to-send, then shifts start, 8 data
// bits LSB first, odd parity and stop on device clock falling edges, samples
// the device ACK and waits for both lines to return idle.
//   clk, rstN            : system clock, async active-low reset
//   txData, txValid      : command byte and request (accepted when txReady)
//   txReady              : high only while idle
//   txDone, txError      : end-of-frame pulse; error = no ACK or timeout
//   kbdClkIn, kbdDataIn  : raw PS/2 line levels
//   kbdClkOe, kbdDataOe  : 1 = pull the line low, 0 = release
// Optional macro PS2_TX_TIMEOUT_EN adds a watchdog on device clock activity.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50000000,
  parameter int unsigned INHIBIT_US  = 100,
  parameter int unsigned TIMEOUT_US  = 15000
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic [7:0] txData,
  input  logic       txValid,
  output logic       txReady,
  output logic       txDone,
  output logic       txError,
  input  logic       kbdClkIn,
  input  logic       kbdDataIn,
  output logic       kbdClkOe,
  output logic       kbdDataOe
);

  localparam int unsigned INHIBIT_CYC = usToCycles(CLK_FREQ_HZ, INHIBIT_US);
  localparam int unsigned INH_W       = $clog2(INHIBIT_CYC + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYC - 1);

  ps2TxState_t      state;
  logic [7:0]       txByte;
  logic             parityBit;
  logic [2:0]       bitIdx;
  logic [INH_W-1:0] inhCnt;
  logic             ackErr;

  logic clkSync;
  logic dataSync;
  logic fallEdge;
  logic linesIdle;
  logic wdTimeout;

  ps2_sync_edge uSync (
    .clk      (clk),
    .rstN     (rstN),
    .clkIn    (kbdClkIn),
    .dataIn   (kbdDataIn),
    .clkSync  (clkSync),
    .dataSync (dataSync),
    .fallEdge (fallEdge)
  );

  assign linesIdle = clkSync & dataSync;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned TIMEOUT_CYC = usToCycles(CLK_FREQ_HZ, TIMEOUT_US);
  localparam int unsigned WD_W        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic [WD_W-1:0] wdCnt;
  logic            wdActive;
  logic            wdProgress;

  // Watchdog runs from REQ through WAITIDLE; any device clock edge (or idle
  // lines while waiting to finish) counts as progress.
  assign wdActive   = (state != IDLE) && (state != INHIBIT);
  assign wdProgress = fallEdge || ((state == WAITIDLE) && linesIdle);
  assign wdTimeout  = wdActive && !wdProgress && (wdCnt == WD_LAST);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wdCnt <= '0;
    end else if (!wdActive || wdProgress || wdTimeout) begin
      wdCnt <= '0;
    end else begin
      wdCnt <= wdCnt + 1'b1;
    end
  end
`else
  assign wdTimeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= IDLE;
      txByte    <= '0;
      parityBit <= 1'b0;
      bitIdx    <= '0;
      inhCnt    <= '0;
      ackErr    <= 1'b0;
      txDone    <= 1'b0;
      txError   <= 1'b0;
    end else begin
      txDone <= 1'b0;
      if (wdTimeout) begin
        state   <= IDLE;
        txDone  <= 1'b1;
        txError <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (txValid) begin
              txByte    <= txData;
              parityBit <= oddParity(txData);
              inhCnt    <= '0;
              state     <= INHIBIT;
            end
          end
          INHIBIT: begin
            if (inhCnt == INH_LAST) begin
              state <= REQ;
            end else begin
              inhCnt <= inhCnt + 1'b1;
            end
          end
          REQ: begin
            if (fallEdge) begin
              bitIdx <= '0;
              state  <= DATA;
            end
          end
          DATA: begin
            if (fallEdge) begin
              if (bitIdx == 3'd7) begin
                state <= PARITY;
              end else begin
                bitIdx <= bitIdx + 1'b1;
              end
            end
          end
          PARITY: begin
            if (fallEdge) state <= STOP;
          end
          STOP: begin
            if (fallEdge) state <= ACK;
          end
          ACK: begin
            if (fallEdge) begin
              ackErr <= dataSync;
              state  <= WAITIDLE;
            end
          end
          WAITIDLE: begin
            if (linesIdle) begin
              txDone  <= 1'b1;
              txError <= ackErr;
              state   <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Line drives decode straight from registered state so reset releases the
  // lines asynchronously and data only moves on the cycle after a fallEdge.
  always_comb begin
    kbdClkOe  = 1'b0;
    kbdDataOe = 1'b0;
    case (state)
      INHIBIT: begin
        kbdClkOe  = 1'b1;
        kbdDataOe = (inhCnt == INH_LAST);
      end
      REQ:     kbdDataOe = 1'b1;
      DATA:    kbdDataOe = ~txByte[bitIdx];
      PARITY:  kbdDataOe = ~parityBit;
      default: kbdDataOe = 1'b0;
    endcase
  end

  assign txReady = (state == IDLE);

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 50000000, system clock frequency.
REQ-002 SHALL have parameter INHIBIT_US, default 100, clock-inhibit time before the start bit.
REQ-003 SHALL have parameter TIMEOUT_US, default 15000, maximum gap between device clock falling edges.
REQ-004 SHALL have port clk, input, 1, sole system clock; all state on posedge clk.
REQ-005 SHALL have port rstN, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port txData, input, 8, command byte to send to the keyboard.
REQ-007 SHALL have port txValid, input, 1, request; byte accepted when txValid && txReady.
REQ-008 SHALL have port txReady, output, 1, high only in IDLE.
REQ-009 SHALL have port txDone, output, 1, one-cycle pulse at frame end.
REQ-010 SHALL have port txError, output, 1, valid with txDone; 1 = no ACK or timeout.
REQ-011 SHALL have ports kbdClkIn and kbdDataIn, inputs, 1 each, raw asynchronous PS/2 line levels.
REQ-012 SHALL have ports kbdClkOe and kbdDataOe, outputs, 1 each; 1 = pull the open-drain line low, 0 = release.

Function
REQ-013 SHALL pass kbdClkIn through a 2-FF synchroniser and detect falling edges (fallEdge) on the synchronised value; kbdDataIn SHALL be 2-FF synchronised.
REQ-014 SHALL implement states IDLE, INHIBIT, REQ, DATA, PARITY, STOP, ACK, WAITIDLE.
REQ-015 IDLE: both Oe = 0; on accept, latch txData and compute odd parity (parity bit = ~^txData); go to INHIBIT.
REQ-016 INHIBIT: kbdClkOe = 1 for exactly CLK_FREQ_HZ/1000000*INHIBIT_US cycles; kbdDataOe = 1 in its final cycle; then REQ.
REQ-017 REQ: kbdClkOe = 0, kbdDataOe = 1 (start bit 0); first fallEdge -> DATA with bit index 0.
REQ-018 DATA: kbdDataOe = ~txByte[idx]; on fallEdge idx increments; fallEdge at idx 7 -> PARITY.
REQ-019 PARITY: kbdDataOe = ~parity; fallEdge -> STOP.
REQ-020 STOP: kbdDataOe = 0 (stop bit 1); fallEdge -> ACK.
REQ-021 ACK: on fallEdge sample synchronised data; 0 = ACK ok, 1 = error latched; go to WAITIDLE.
REQ-022 WAITIDLE: wait until both synchronised lines are 1; then pulse txDone with txError = latched error, return to IDLE.
REQ-023 kbdDataOe changes only on the cycle after fallEdge, never while the device clock is high.
REQ-024 txValid outside IDLE SHALL be ignored; txData is not resampled mid-frame.
REQ-025 fallEdge in IDLE or INHIBIT SHALL be ignored; the device-to-host receive path is outside this block.

Reset
REQ-026 rstN low SHALL force IDLE asynchronously, with kbdClkOe = kbdDataOe = 0, txReady = 1, txDone = 0, txError = 0, counters and synchronisers cleared to idle-high line values.
REQ-027 Reset mid-frame SHALL release both lines immediately and SHALL NOT produce txDone.

Configuration
REQ-028 With macro PS2_TX_TIMEOUT_EN defined: in REQ through WAITIDLE, a gap of CLK_FREQ_HZ/1000000*TIMEOUT_US cycles without fallEdge (or without lines idle in WAITIDLE) SHALL release both lines and pulse txDone with txError = 1, then return to IDLE.
REQ-029 Without PS2_TX_TIMEOUT_EN: no watchdog counter is present, and the block waits indefinitely.

Structure
REQ-030 Package ps2_pkg SHALL hold the state enum typedef, a function converting microseconds to cycles, and the PS/2 frame constants (11 clocks, odd parity).
REQ-031 Sub-module ps2_sync_edge SHALL hold the 2-FF synchroniser and falling-edge detector, reusable by the receiver.

Verification
REQ-032 txData = 0xED, device model clocks at 12.5 kHz, ACK = 0 -> device sees start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1; txDone = 1, txError = 0.
REQ-033 txData = 0x01 -> parity bit 0; txData = 0x00 -> parity bit 1; both frames complete with no error.
REQ-034 Device leaves data high at the ACK clock -> txDone = 1, txError = 1, lines released.
REQ-035 kbdClkOe high for exactly 5000 cycles at 50 MHz; txValid pulsed again during the frame is ignored, and txReady stays 0 until txDone.
REQ-036 PS2_TX_TIMEOUT_EN defined, device never clocks -> after 750000 cycles, txDone = 1, txError = 1, and both Oe = 0.
REQ-037 rstN asserted after 4 data bits -> both Oe drop to 0 the same cycle, no txDone; the next request then completes normally.
